sar_busca: RTL
==============

SAR_BUSCA -- requirements
Module: sar_busca

Interface
REQ-001 Parameter: LARGURA, default 4, width of the searched value and of the candidate bus.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-005 Port: cand  output  LARGURA  registered candidate driven to comparator input B (target on comparator input A).
REQ-006 Port: gt  input  1  comparator: target > cand, valid combinationally in the same cycle as cand.
REQ-007 Port: lt  input  1  comparator: target < cand.
REQ-008 Port: eq  input  1  comparator: target == cand.
REQ-009 Port: result  output  LARGURA  registered search result, held until next start.
REQ-010 Port: done  output  1  one-cycle pulse: result is valid.
REQ-011 Port: busy  output  1  high while a search is in progress (TEST state).
REQ-012 Port: err  output  1  sticky flag: comparator returned a non-one-hot {gt,lt,eq} code.

Function
REQ-013 FSM states SHALL be IDLE, TEST, FIM; a bit index idx (0..LARGURA-1) SHALL track the bit under test.
REQ-014 IDLE: cand=0, busy=0, done=0; start=1 -> next cycle TEST, idx=LARGURA-1, cand=1<<(LARGURA-1), err=0, result=0.
REQ-015 TEST, each cycle: sample {gt,lt,eq} against the current cand; exactly one SHALL be high for a legal code.
REQ-016 TEST, eq=1: result<=cand, go to FIM (early termination).
REQ-017 TEST, lt=1, idx>0: clear bit idx of cand, set bit idx-1, idx<=idx-1.
REQ-018 TEST, gt=1, idx>0: keep bit idx of cand, set bit idx-1, idx<=idx-1.
REQ-019 TEST, idx=0, lt=1: result<=cand with bit 0 cleared, go to FIM; gt=1: result<=cand, go to FIM.
REQ-020 TEST, illegal code (zero or more than one of gt/lt/eq high): err<=1, result<=0, go to FIM.
REQ-021 FIM: done=1 for exactly one cycle, busy=0, cand<=0; next state IDLE.
REQ-022 Latency: done SHALL be high no later than LARGURA+1 cycles after the cycle start is sampled, and no earlier than 2.
REQ-023 start while in TEST or FIM SHALL be ignored; it has no effect on the running search.
REQ-024 result and err SHALL hold their values through IDLE until the next accepted start.
REQ-025 All arithmetic is unsigned; cand never exceeds 2^LARGURA-1, and no wrap-around of idx below 0 SHALL occur.

Reset
REQ-026 rst=1 SHALL force IDLE with cand=0, result=0, done=0, busy=0, err=0, idx=LARGURA-1, regardless of state, including mid-TEST.
REQ-027 rst has priority over start in the same cycle; the search is not started.

Verification
REQ-028 Target 9 (behavioral comparator), start pulse -> cand sequence 8,12,10,9; eq on 9; done 5 cycles after start, result=9, err=0.
REQ-029 Target 0 -> cand 8,4,2,1 all lt; done 5 cycles after start, result=0, err=0.
REQ-030 Target 8 -> eq on first candidate 8; done 2 cycles after start, result=8.
REQ-031 Target 15 -> cand 8,12,14,15; eq on 15; result=15. Target 7 -> cand 8,4,6,7; eq on 7; result=7.
REQ-032 Force gt=1 and eq=1 together in the first TEST cycle -> err=1, result=0, done pulse next cycle; err stays 1 until the next start.
REQ-033 Assert rst in the second TEST cycle -> all outputs 0 next cycle, state IDLE; a start 1 cycle later runs a normal search; a start held during busy is ignored.

Source files
------------

// File: rtl/sar_busca_if.sv
// sar_busca_if: handshake and comparator bus between a SAR searcher and its requester/comparator.
//   start  : request a new search
//   cand   : candidate presented to comparator input B
//   gt/lt/eq : comparator verdict of target versus cand
//   result : search result, done : one-cycle result strobe
//   busy   : search in progress, err : sticky illegal-comparator-code flag
interface sar_busca_if #(parameter int LARGURA = 4);
    logic               start;
    logic [LARGURA-1:0] cand;
    logic               gt;
    logic               lt;
    logic               eq;
    logic [LARGURA-1:0] result;
    logic               done;
    logic               busy;
    logic               err;
    modport slave (input start, gt, lt, eq, output cand, result, done, busy, err);
    modport master (output start, gt, lt, eq, input cand, result, done, busy, err);
endinterface

// File: rtl/sar_busca.sv
// sar_busca: successive-approximation search of a target through an external comparator.
//   clk : clock, rst : synchronous active-high reset
//   bus : sar_busca_if slave (start/gt/lt/eq in; cand/result/done/busy/err out)
module sar_busca #(parameter int LARGURA = 4) (
    input logic         clk,
    input logic         rst,
    sar_busca_if.slave  bus
);
    localparam int IW = LARGURA > 1 ? $clog2(LARGURA) : 1;
    typedef enum logic [1:0] {IDLE, TEST, FIM} estado_t;
    estado_t            estado_q;
    logic [IW-1:0]      idx_q;
    logic [LARGURA-1:0] cand_q;
    logic [LARGURA-1:0] result_q;
    logic               done_q;
    logic               busy_q;
    logic               err_q;
    logic               legal;
    assign legal = {bus.gt, bus.lt, bus.eq} inside {3'b100, 3'b010, 3'b001};
    assign bus.cand   = cand_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            idx_q    <= IW'(LARGURA-1);
            cand_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    cand_q <= '0;
                    if (bus.start) begin
                        estado_q <= TEST;
                        busy_q   <= 1'b1;
                        idx_q    <= IW'(LARGURA-1);
                        cand_q   <= LARGURA'(1) << (LARGURA-1);
                        err_q    <= 1'b0;
                        result_q <= '0;
                    end
                end
                TEST: begin
                    // Every exit from TEST lands in FIM with the strobe already raised,
                    // so done coincides with the FIM cycle.
                    if (!legal || bus.eq || idx_q == '0) begin
                        estado_q <= FIM;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cand_q   <= '0;
                        err_q    <= err_q | !legal;
                        result_q <= !legal ? '0 :
                                    bus.eq ? cand_q :
                                    bus.lt ? (cand_q & ~LARGURA'(1)) : cand_q;
                    end else begin
                        if (bus.lt) cand_q[idx_q] <= 1'b0;
                        cand_q[idx_q - IW'(1)] <= 1'b1;
                        idx_q <= idx_q - IW'(1);
                    end
                end
                FIM: begin
                    estado_q <= IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    cand_q   <= '0;
                    idx_q    <= IW'(LARGURA-1);
                end
                default: estado_q <= IDLE;
            endcase
        end
    end
endmodule
